// File: rtl/morse_tx_if.sv
// rtl/morse_tx_if.sv - letter handshake bundle between the key front end and morse_tx
interface morse_tx_if;
  logic       in_valid;
  logic [4:0] in_code;
  logic       in_ready;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - A-Z Morse letter transmitter with programmable unit tick and repeat mode
module morse_tx #(
  parameter int TICK_DIV   = 25000000,
  parameter int DASH_UNITS = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic      i_clk,
  input  logic      i_reset,
  morse_tx_if.slave s_in,
  input  logic      i_repeat,
  output logic      o_out,
  output logic      o_busy,
  output logic      o_done,
  output logic      o_err
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PEN  = (TICK_DIV > 1) ? TW'(TICK_DIV - 2) : '0;
  localparam logic [3:0] DASH_LEN  = 4'(DASH_UNITS);
  localparam logic [3:0] LGAP_LEN  = 4'(LETTER_GAP);
  localparam logic [3:0] WGAP_LEN  = 4'(WORD_GAP);
  localparam bit         SKIP_GAP  = (LETTER_GAP * TICK_DIV == 1);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_unit;
  logic [1:0]    r_sym, w_sym_nxt;
  logic [2:0]    r_len;
  logic [3:0]    r_pat;
  logic          r_rep, r_out, r_done, r_err;
  logic          w_done_nxt, w_err_nxt, w_load;
  logic [3:0]    w_need;
  logic          w_tick_wrap, w_unit_end, w_last_sym, w_gap_early;
  logic [6:0]    w_entry;

  // {length, pattern}; pattern bit0 is the first symbol, 1 = dash
  function automatic logic [6:0] code_entry(input logic [4:0] c);
    case (c)
      5'd0:  code_entry = {3'd2, 4'b0010};
      5'd1:  code_entry = {3'd4, 4'b0001};
      5'd2:  code_entry = {3'd4, 4'b0101};
      5'd3:  code_entry = {3'd3, 4'b0001};
      5'd4:  code_entry = {3'd1, 4'b0000};
      5'd5:  code_entry = {3'd4, 4'b0100};
      5'd6:  code_entry = {3'd3, 4'b0011};
      5'd7:  code_entry = {3'd4, 4'b0000};
      5'd8:  code_entry = {3'd2, 4'b0000};
      5'd9:  code_entry = {3'd4, 4'b1110};
      5'd10: code_entry = {3'd3, 4'b0101};
      5'd11: code_entry = {3'd4, 4'b0010};
      5'd12: code_entry = {3'd2, 4'b0011};
      5'd13: code_entry = {3'd2, 4'b0001};
      5'd14: code_entry = {3'd3, 4'b0111};
      5'd15: code_entry = {3'd4, 4'b0110};
      5'd16: code_entry = {3'd4, 4'b1011};
      5'd17: code_entry = {3'd3, 4'b0010};
      5'd18: code_entry = {3'd3, 4'b0000};
      5'd19: code_entry = {3'd1, 4'b0001};
      5'd20: code_entry = {3'd3, 4'b0100};
      5'd21: code_entry = {3'd4, 4'b1000};
      5'd22: code_entry = {3'd3, 4'b0110};
      5'd23: code_entry = {3'd4, 4'b1001};
      5'd24: code_entry = {3'd4, 4'b1101};
      5'd25: code_entry = {3'd4, 4'b0011};
      default: code_entry = 7'd0;
    endcase
  endfunction

  assign w_entry     = code_entry(s_in.in_code);
  assign w_need      = (r_state == S_MARK) ? (r_pat[r_sym] ? DASH_LEN : 4'd1) :
                       (r_state == S_GAP)  ? WGAP_LEN : 4'd1;
  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_unit_end  = w_tick_wrap && (({1'b0, r_unit} + 4'd1) == w_need);
  assign w_last_sym  = (({1'b0, r_sym} + 3'd1) == r_len);
  // A single letter's gap hands its final cycle to the IDLE/done cycle, so the
  // next letter can start exactly LETTER_GAP units after the last mark.
  assign w_gap_early = (TICK_DIV > 1) ?
                       ((({1'b0, r_unit} + 4'd1) == LGAP_LEN) && (r_tick == TICK_PEN)) :
                       (({1'b0, r_unit} + 4'd2) == LGAP_LEN);

  always_comb begin
    w_state_nxt = r_state;
    w_sym_nxt   = r_sym;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s_in.in_valid) begin
          if (s_in.in_code > 5'd25) begin
            w_err_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_sym_nxt   = 2'd0;
            w_state_nxt = S_MARK;
          end
        end
      end
      S_MARK: begin
        if (w_unit_end) begin
          if (!w_last_sym) begin
            w_state_nxt = S_SPACE;
          end else if (!i_repeat && SKIP_GAP) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
          end
        end
      end
      S_SPACE: begin
        if (w_unit_end) begin
          w_state_nxt = S_MARK;
          w_sym_nxt   = r_sym + 2'd1;
        end
      end
      S_GAP: begin
        if (r_rep) begin
          if (w_unit_end) begin
            w_state_nxt = S_MARK;
            w_sym_nxt   = 2'd0;
          end
        end else if (w_gap_early) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_unit  <= '0;
      r_sym   <= '0;
      r_len   <= '0;
      r_pat   <= '0;
      r_rep   <= 1'b0;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sym   <= w_sym_nxt;
      r_out   <= (w_state_nxt == S_MARK);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_load) begin
        r_len <= w_entry[6:4];
        r_pat <= w_entry[3:0];
      end
      if (r_state == S_MARK && w_unit_end && w_last_sym) begin
        r_rep <= i_repeat;
      end
      if (w_state_nxt != r_state || w_load) begin
        r_tick <= '0;
        r_unit <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_tick_wrap) begin
          r_tick <= '0;
          r_unit <= r_unit + 3'd1;
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end
    end
  end

  assign s_in.in_ready = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_out         = r_out;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
